// File: rtl/ddr_a2m_mbaarb_pkg.sv
// ---------------------------------------------------------------------------
// ddr_a2m_mbaarb_pkg
//   Shared definitions for the MBA request arbiter slice:
//   - MBA field widths (ADR[29:2] is 28 bits, BST[9:2] is 8 bits)
//   - FSM state encoding (IDLE / GRANT / HOLD)
//   - modulo helper used for round-robin pointer arithmetic
// ---------------------------------------------------------------------------
package ddr_a2m_mbaarb_pkg;

  localparam int ADR_W = 28;
  localparam int BST_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } mba_state_e;

  // (a + b) mod n for 0 <= a, b < n; port counts are not always powers of two,
  // so the wrap is done against n rather than by truncating to the pointer width.
  function automatic int rr_wrap_add(input int a, input int b, input int n);
    int sum_v;
    sum_v = a + b;
    if (sum_v >= n) begin
      return sum_v - n;
    end else begin
      return sum_v;
    end
  endfunction

endpackage

// File: rtl/ddr_a2m_mbaarb_if.sv
// ---------------------------------------------------------------------------
// ddr_a2m_mbaarb_if
//   Bundle of the bridge-side (P_*) and MBA-side (M_*) signals of the arbiter.
//   master : arbiter view (drives M_REQ/M_RZW/M_ADR/M_BST, P_REL/P_NEL,
//            GNT_ID, TIMEOUT; receives P_REQ/P_RZW/P_ADR/P_BST, M_REL/M_NEL)
//   slave  : environment view (the opposite directions)
//   P_REQ is active-low; M_REQ is active-low; M_REL/M_NEL are active-high.
// ---------------------------------------------------------------------------
interface ddr_a2m_mbaarb_if
  import ddr_a2m_mbaarb_pkg::*;
#(
  parameter int P_NPORT = 2,
  parameter int P_PW    = 1
);
  logic [P_NPORT-1:0]       P_REQ;
  logic [P_NPORT-1:0]       P_RZW;
  logic [ADR_W*P_NPORT-1:0] P_ADR;
  logic [BST_W*P_NPORT-1:0] P_BST;
  logic [P_NPORT-1:0]       P_REL;
  logic [P_NPORT-1:0]       P_NEL;
  logic                     M_REQ;
  logic                     M_REL;
  logic                     M_NEL;
  logic                     M_RZW;
  logic [ADR_W-1:0]         M_ADR;
  logic [BST_W-1:0]         M_BST;
  logic [P_PW-1:0]          GNT_ID;
  logic                     TIMEOUT;

  modport master (
    input  P_REQ, P_RZW, P_ADR, P_BST, M_REL, M_NEL,
    output P_REL, P_NEL, M_REQ, M_RZW, M_ADR, M_BST, GNT_ID, TIMEOUT
  );

  modport slave (
    output P_REQ, P_RZW, P_ADR, P_BST, M_REL, M_NEL,
    input  P_REL, P_NEL, M_REQ, M_RZW, M_ADR, M_BST, GNT_ID, TIMEOUT
  );

endinterface

// File: rtl/ddr_a2m_mbaarb_chk.sv
// ---------------------------------------------------------------------------
// ddr_a2m_mbaarb_chk
//   Protocol monitor for the arbiter: the granted port must keep its P_REQ
//   low for as long as the grant is outstanding, and GNT_ID must always name
//   an existing port. The design tolerates a violation; this only reports it.
//   in_grant : arbiter is in GRANT
//   gnt_id   : current grant owner
//   p_req    : per-port request, active-low
// ---------------------------------------------------------------------------
module ddr_a2m_mbaarb_chk #(
  parameter int P_NPORT = 2,
  parameter int P_PW    = 1
) (
  input logic               CLK,
  input logic               RESET,
  input logic               in_grant,
  input logic [P_PW-1:0]    gnt_id,
  input logic [P_NPORT-1:0] p_req
);

  a_req_held: assert property (@(posedge CLK) disable iff (RESET)
    in_grant |-> !p_req[gnt_id]);

  a_gnt_range: assert property (@(posedge CLK) disable iff (RESET)
    int'(gnt_id) < P_NPORT);

endmodule

// File: rtl/ddr_a2m_mbaarb_rrpick.sv
// ---------------------------------------------------------------------------
// ddr_a2m_rrpick
//   Combinational round-robin picker: rotate the request vector so that the
//   pointer position lands at bit 0, take the lowest set bit, then rotate the
//   found offset back to an absolute port index.
//   req : active-high request vector
//   ptr : round-robin start position
//   sel : chosen port (valid when any=1)
//   any : at least one request present
// ---------------------------------------------------------------------------
module ddr_a2m_rrpick
  import ddr_a2m_mbaarb_pkg::*;
#(
  parameter int P_NPORT = 2,
  parameter int P_PW    = 1
) (
  input  logic [P_NPORT-1:0] req,
  input  logic [P_PW-1:0]    ptr,
  output logic [P_PW-1:0]    sel,
  output logic               any
);

  int                 base_s;
  int                 off_s;
  logic [P_NPORT-1:0] rot_s;

  // Rotate, priority-encode from the pointer, unrotate.
  always_comb begin
    // An out-of-range pointer (only possible for non power-of-two port counts)
    // restarts the search at port 0.
    if (int'(ptr) < P_NPORT) begin
      base_s = int'(ptr);
    end else begin
      base_s = 32'sd0;
    end
    rot_s = '0;
    for (int k = 0; k < P_NPORT; k++) begin
      rot_s[k] = req[P_PW'(rr_wrap_add(base_s, k, P_NPORT))];
    end
    off_s = 32'sd0;
    for (int k = P_NPORT - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? k : off_s;
    end
    sel = P_PW'(rr_wrap_add(base_s, off_s, P_NPORT));
    any = |req;
  end

endmodule

// File: rtl/ddr_a2m_mbaarb.sv
// ---------------------------------------------------------------------------
// ddr_a2m_mbaarb
//   Round-robin arbiter sharing one MBA request port between P_NPORT bridge
//   request controllers. One request is forwarded at a time; the MBA release
//   is returned to the owner as a one-cycle P_REL, and P_NEL tells idle ports
//   that a new request may be posted. A sticky watchdog flags a grant that the
//   MBA never releases. All outputs are registered.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : master view of ddr_a2m_mbaarb_if (P_* per-port, M_* MBA,
//                GNT_ID owner of current/last grant, TIMEOUT watchdog flag)
// ---------------------------------------------------------------------------
module ddr_a2m_mbaarb
  import ddr_a2m_mbaarb_pkg::*;
#(
  parameter int P_NPORT = 2,
  parameter int P_PW    = 1,
  parameter int P_TOW   = 12
) (
  input  logic              CLK,
  input  logic              RESET,
  ddr_a2m_mbaarb_if.master  bus
);

  localparam logic [P_TOW-1:0]   WD_MAX   = {P_TOW{1'b1}};
  localparam logic [P_NPORT-1:0] ONE_HOT0 = {{(P_NPORT-1){1'b0}}, 1'b1};

  mba_state_e         state_r, state_s;
  logic [P_PW-1:0]    rr_ptr_r, rr_ptr_s;
  logic [P_PW-1:0]    gnt_id_r, gnt_id_s;
  logic               m_req_r, m_req_s;
  logic               m_rzw_r, m_rzw_s;
  logic [ADR_W-1:0]   m_adr_r, m_adr_s;
  logic [BST_W-1:0]   m_bst_r, m_bst_s;
  logic [P_NPORT-1:0] p_rel_r, p_rel_s;
  logic [P_NPORT-1:0] p_nel_r, p_nel_s;
  logic [P_TOW-1:0]   wd_cnt_r, wd_cnt_s;
  logic               timeout_r, timeout_s;

  logic [P_NPORT-1:0] req_act_s;
  logic [P_PW-1:0]    pick_sel_s;
  logic               pick_any_s;

  assign req_act_s = ~bus.P_REQ;

  ddr_a2m_rrpick #(
    .P_NPORT (P_NPORT),
    .P_PW    (P_PW)
  ) u_rrpick (
    .req (req_act_s),
    .ptr (rr_ptr_r),
    .sel (pick_sel_s),
    .any (pick_any_s)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, grant bookkeeping and next values of the registered outputs.
  always_comb begin
    state_s  = state_r;
    rr_ptr_s = rr_ptr_r;
    gnt_id_s = gnt_id_r;
    m_req_s  = m_req_r;
    m_rzw_s  = m_rzw_r;
    m_adr_s  = m_adr_r;
    m_bst_s  = m_bst_r;
    p_rel_s  = '0;
    case (state_r)
      ST_IDLE: begin
        // M_NEL does not gate issue; ports only request after seeing P_NEL.
        if (pick_any_s) begin
          state_s  = ST_GRANT;
          gnt_id_s = pick_sel_s;
          m_req_s  = 1'b0;
          m_rzw_s  = bus.P_RZW[pick_sel_s];
          m_adr_s  = bus.P_ADR[int'(pick_sel_s)*ADR_W +: ADR_W];
          m_bst_s  = bus.P_BST[int'(pick_sel_s)*BST_W +: BST_W];
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // Fields stay frozen; the grant completes even if the owner dropped
        // its request early.
        if (bus.M_REL) begin
          state_s  = ST_HOLD;
          m_req_s  = 1'b1;
          p_rel_s  = ONE_HOT0 << gnt_id_r;
          rr_ptr_s = P_PW'(rr_wrap_add(int'(gnt_id_r), 32'sd1, P_NPORT));
        end else begin
          state_s = ST_GRANT;
        end
      end
      ST_HOLD: begin
        // Gives the released port one cycle to raise P_REQ before re-arbitration.
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        m_req_s = 1'b1;
      end
    endcase
  end

  // Next-enable and watchdog next values.
  always_comb begin
    if (state_r == ST_IDLE) begin
      p_nel_s = bus.P_REQ & {P_NPORT{bus.M_NEL}};
    end else begin
      p_nel_s = '0;
    end
    if (state_r == ST_GRANT) begin
      if (wd_cnt_r != WD_MAX) begin
        wd_cnt_s = wd_cnt_r + {{(P_TOW-1){1'b0}}, 1'b1};
      end else begin
        wd_cnt_s = wd_cnt_r;
      end
    end else begin
      wd_cnt_s = '0;
    end
    // Counter only reaches all-ones while in GRANT, so this is the timeout.
    timeout_s = timeout_r | (wd_cnt_s == WD_MAX);
  end

  // Registered outputs, round-robin pointer and watchdog.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_ptr_r  <= '0;
      gnt_id_r  <= '0;
      m_req_r   <= 1'b1;
      m_rzw_r   <= 1'b0;
      m_adr_r   <= '0;
      m_bst_r   <= '0;
      p_rel_r   <= '0;
      p_nel_r   <= '0;
      wd_cnt_r  <= '0;
      timeout_r <= 1'b0;
    end else begin
      rr_ptr_r  <= rr_ptr_s;
      gnt_id_r  <= gnt_id_s;
      m_req_r   <= m_req_s;
      m_rzw_r   <= m_rzw_s;
      m_adr_r   <= m_adr_s;
      m_bst_r   <= m_bst_s;
      p_rel_r   <= p_rel_s;
      p_nel_r   <= p_nel_s;
      wd_cnt_r  <= wd_cnt_s;
      timeout_r <= timeout_s;
    end
  end

  assign bus.M_REQ   = m_req_r;
  assign bus.M_RZW   = m_rzw_r;
  assign bus.M_ADR   = m_adr_r;
  assign bus.M_BST   = m_bst_r;
  assign bus.P_REL   = p_rel_r;
  assign bus.P_NEL   = p_nel_r;
  assign bus.GNT_ID  = gnt_id_r;
  assign bus.TIMEOUT = timeout_r;

  ddr_a2m_mbaarb_chk #(
    .P_NPORT (P_NPORT),
    .P_PW    (P_PW)
  ) u_chk (
    .CLK      (CLK),
    .RESET    (RESET),
    .in_grant (state_r == ST_GRANT),
    .gnt_id   (gnt_id_r),
    .p_req    (bus.P_REQ)
  );

endmodule

// File: tb/tb_ddr_a2m_mbaarb.sv
// ---------------------------------------------------------------------------
// tb_ddr_a2m_mbaarb
//   Randomized and directed stimulus for ddr_a2m_mbaarb (2 ports, 4-bit
//   watchdog). A behavioural model pushes each predicted grant into a queue;
//   a negedge monitor pops it when the DUT drops M_REQ and also compares the
//   per-cycle outputs against the model.
// ---------------------------------------------------------------------------
module tb_ddr_a2m_mbaarb;
  import ddr_a2m_mbaarb_pkg::*;

  localparam int NP       = 2;
  localparam int PW       = 1;
  localparam int TOW      = 4;
  localparam int WD_LIMIT = (1 << TOW) - 1;

  typedef struct {
    int         port;
    logic       rzw;
    logic [27:0] adr;
    logic [7:0] bst;
  } grant_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  ddr_a2m_mbaarb_if #(.P_NPORT(NP), .P_PW(PW)) bus ();

  ddr_a2m_mbaarb #(.P_NPORT(NP), .P_PW(PW), .P_TOW(TOW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int grants_seen = 0;

  // stimulus controls (written by the sequence just after a posedge)
  int      req_pct = 0;
  int      rel_fix = -1;
  int      rel_max = 4;
  bit      rel_block = 1'b0;
  bit      spur_en = 1'b0;
  bit      spur_force = 1'b0;
  int      nel_mode = 1;
  bit      mon_on = 1'b0;
  logic [NP-1:0] dir_go = '0;
  logic [27:0]   dir_adr [NP];
  logic [7:0]    dir_bst [NP];
  logic          dir_rzw [NP];

  // port driver state
  logic [NP-1:0] pend = '0;
  logic [27:0]   adr_a [NP];
  logic [7:0]    bst_a [NP];
  logic          rzw_a [NP];

  // reference model state
  bit            m_busy = 1'b0;
  int            m_port = 0;
  int            m_wait = 0;
  int            m_ptr = 0;
  int            m_gcnt = 0;
  bit            exp_to = 1'b0;
  logic          exp_mreq = 1'b1;
  int            exp_gnt = 0;
  logic [NP-1:0] exp_prel = '0;
  logic [NP-1:0] exp_nel = '0;
  grant_t        exp_q [$];

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Requesters: raise P_REQ when the model says the port was released,
  // otherwise post new requests (directed or random) and hold them.
  always @(negedge CLK) begin
    for (int i = 0; i < NP; i++) begin
      if (RESET) begin
        pend[i] = 1'b0;
        bus.P_REQ[i] = 1'b1;
      end else if (pend[i] && exp_prel[i]) begin
        pend[i] = 1'b0;
        bus.P_REQ[i] = 1'b1;
      end else if (!pend[i] && (dir_go[i] || (int'($urandom % 100) < req_pct))) begin
        if (dir_go[i]) begin
          adr_a[i] = dir_adr[i];
          bst_a[i] = dir_bst[i];
          rzw_a[i] = dir_rzw[i];
        end else begin
          adr_a[i] = 28'($urandom);
          bst_a[i] = 8'($urandom);
          rzw_a[i] = 1'($urandom);
        end
        pend[i] = 1'b1;
        bus.P_REQ[i] = 1'b0;
      end
      bus.P_ADR[i*28 +: 28] = adr_a[i];
      bus.P_BST[i*8 +: 8]   = bst_a[i];
      bus.P_RZW[i]          = rzw_a[i];
    end
  end

  // MBA responder: release after a delay once M_REQ is low; optional
  // spurious M_REL while M_REQ is high; M_NEL selected by nel_mode.
  bit armed = 1'b0;
  int rcnt = 0;
  always @(negedge CLK) begin
    bus.M_NEL = (nel_mode == 0) ? 1'b0 : (nel_mode == 1) ? 1'b1 : 1'($urandom);
    if (RESET) begin
      armed = 1'b0;
      bus.M_REL = 1'b0;
    end else if (bus.M_REQ == 1'b0) begin
      if (!armed) begin
        armed = 1'b1;
        rcnt = (rel_fix >= 0) ? rel_fix : int'($urandom % (rel_max + 1));
      end else if (rcnt > 0) begin
        rcnt--;
      end
      bus.M_REL = (rcnt == 0) && !rel_block;
    end else begin
      armed = 1'b0;
      bus.M_REL = spur_force || (spur_en && ($urandom % 8 == 0));
    end
  end

  // Reference model: one grant at a time, round-robin from the port after
  // the last owner, one dead cycle after every release.
  always @(posedge CLK) begin
    if (RESET) begin
      m_busy = 1'b0; m_wait = 0; m_ptr = 0; m_gcnt = 0;
      exp_to = 1'b0; exp_mreq = 1'b1; exp_gnt = 0;
      exp_prel = '0; exp_nel = '0;
      exp_q.delete();
    end else begin
      exp_nel = (!m_busy && m_wait == 0 && bus.M_NEL) ? bus.P_REQ : '0;
      exp_prel = '0;
      if (m_busy) begin
        m_gcnt++;
        if (m_gcnt >= WD_LIMIT) exp_to = 1'b1;
        if (bus.M_REL) begin
          m_busy = 1'b0;
          exp_prel[m_port] = 1'b1;
          m_ptr = (m_port + 1) % NP;
          m_wait = 1;
          exp_mreq = 1'b1;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else begin
        bit found;
        found = 1'b0;
        for (int k = 0; k < NP; k++) begin
          int p;
          p = (m_ptr + k) % NP;
          if (!found && pend[p]) begin
            found = 1'b1;
            m_busy = 1'b1; m_port = p; m_gcnt = 0;
            exp_mreq = 1'b0; exp_gnt = p;
            exp_q.push_back('{port: p, rzw: rzw_a[p], adr: adr_a[p], bst: bst_a[p]});
          end
        end
      end
    end
  end

  // Monitor: per-cycle output checks plus grant scoreboard.
  logic   mreq_prev = 1'b1;
  bit     have_cur = 1'b0;
  grant_t cur;
  always @(negedge CLK) begin
    if (mon_on) begin
      check("M_REQ", 64'(bus.M_REQ), 64'(exp_mreq));
      check("P_REL", 64'(bus.P_REL), 64'(exp_prel));
      check("P_NEL", 64'(bus.P_NEL), 64'(exp_nel));
      check("TIMEOUT", 64'(bus.TIMEOUT), 64'(exp_to));
      check("GNT_ID", 64'(bus.GNT_ID), 64'(exp_gnt));
      if (mreq_prev && !bus.M_REQ) begin
        if (exp_q.size() == 0) begin
          check("grant_expected", 64'(1), 64'(0));
          have_cur = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          grants_seen++;
          check("grant_port", 64'(bus.GNT_ID), 64'(cur.port));
        end
      end
      if (!bus.M_REQ && have_cur) begin
        check("M_RZW", 64'(bus.M_RZW), 64'(cur.rzw));
        check("M_ADR", 64'(bus.M_ADR), 64'(cur.adr));
        check("M_BST", 64'(bus.M_BST), 64'(cur.bst));
      end
    end
    mreq_prev = bus.M_REQ;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic go(input logic [NP-1:0] ports);
    dir_go = ports;
    cycles(1);
    dir_go = '0;
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      dir_adr[i] = 28'h0;
      dir_bst[i] = 8'h0;
      dir_rzw[i] = 1'b0;
      adr_a[i] = 28'h0;
      bst_a[i] = 8'h0;
      rzw_a[i] = 1'b0;
    end
    RESET = 1'b1;
    cycles(3);
    RESET = 1'b0;
    mon_on = 1'b1;
    cycles(2);

    // single port, fixed fields
    dir_adr[0] = 28'h0001234; dir_bst[0] = 8'h0F; dir_rzw[0] = 1'b0;
    rel_fix = 3;
    go(2'b01);
    cycles(12);

    // next-enable gating
    nel_mode = 0;
    cycles(4);
    nel_mode = 1;
    cycles(4);
    dir_adr[1] = 28'hABCDEF1; dir_bst[1] = 8'h80; dir_rzw[1] = 1'b1;
    rel_fix = 1;
    go(2'b10);
    cycles(10);

    // simultaneous requests
    dir_adr[0] = 28'h0000010; dir_bst[0] = 8'h01;
    dir_adr[1] = 28'hFFFFFF0; dir_bst[1] = 8'hFE;
    rel_fix = 2;
    go(2'b11);
    cycles(20);

    // fairness: both ports always requesting
    rel_fix = -1; rel_max = 3; req_pct = 100;
    cycles(60);

    // random traffic with spurious releases and random M_NEL
    req_pct = 30; spur_en = 1'b1; nel_mode = 2; rel_max = 6;
    cycles(400);
    req_pct = 0; spur_en = 1'b0; nel_mode = 1;
    cycles(30);

    // watchdog: hold release off, then complete the grant
    rel_block = 1'b1; rel_fix = 0;
    go(2'b01);
    cycles(25);
    rel_block = 1'b0;
    cycles(10);

    // reset in the middle of a grant, then a spurious release
    rel_block = 1'b1;
    go(2'b10);
    cycles(4);
    RESET = 1'b1;
    cycles(1);
    RESET = 1'b0;
    spur_force = 1'b1;
    cycles(1);
    spur_force = 1'b0;
    rel_block = 1'b0;
    cycles(5);

    // more random traffic after reset
    rel_fix = -1; req_pct = 40; spur_en = 1'b1; nel_mode = 2;
    cycles(200);
    req_pct = 0; spur_en = 1'b0;
    cycles(30);

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("enough_grants", 64'(grants_seen > 20), 64'(1));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
